// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - two-read one-write register file with registered read ports
//
// Register bank for the single-cycle MIPS datapath. Register 0 always reads
// as zero. Storage is flip-flops; both read ports are registered, so no input
// reaches an output without passing through a clock edge.
//
// Ports:
//   clk      - system clock, rising-edge active
//   rst_n    - asynchronous active-low reset (clears storage and read outputs)
//   we       - write enable
//   waddr    - write address
//   wdata    - write data
//   re_a     - port A read enable
//   raddr_a  - port A read address
//   rdata_a  - port A registered read data (holds when no read is issued)
//   rvalid_a - port A one-cycle valid pulse per accepted read
//   re_b     - port B read enable
//   raddr_b  - port B read address
//   rdata_b  - port B registered read data (holds when no read is issued)
//   rvalid_b - port B one-cycle valid pulse per accepted read

module regfile_2r1w #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              rvalid_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid_b
);

  // Only entries 1..DEPTH-1 exist as storage; register 0 is a constant zero
  // produced by the read muxes, so it can never be corrupted by a write.
  logic [DEPTH-1:1][WIDTH-1:0] entry;

  logic [WIDTH-1:0] rd_val_a;
  logic [WIDTH-1:0] rd_val_b;

  // Write port: a write addressed to register 0 matches no entry and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry <= '0;
    end else if (we) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (waddr == ADDR_W'(i)) begin
          entry[i] <= wdata;
        end
      end
    end
  end

  // Port A read value. The bypass makes a read on the same edge as a write
  // to that address return the new data, so the datapath sees write-through.
  always_comb begin
    rd_val_a = '0;
    if (raddr_a != '0) begin
      if (we && (waddr == raddr_a)) begin
        rd_val_a = wdata;
      end else begin
        for (int i = 1; i < DEPTH; i++) begin
          if (raddr_a == ADDR_W'(i)) begin
            rd_val_a = entry[i];
          end
        end
      end
    end
  end

  // Port B read value, identical rules to port A.
  always_comb begin
    rd_val_b = '0;
    if (raddr_b != '0) begin
      if (we && (waddr == raddr_b)) begin
        rd_val_b = wdata;
      end else begin
        for (int i = 1; i < DEPTH; i++) begin
          if (raddr_b == ADDR_W'(i)) begin
            rd_val_b = entry[i];
          end
        end
      end
    end
  end

  // Port A output register: data only updates alongside a valid pulse, so a
  // consumer can sample rdata_a any time after the pulse and still see it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a  <= '0;
      rvalid_a <= 1'b0;
    end else begin
      rvalid_a <= re_a;
      if (re_a) begin
        rdata_a <= rd_val_a;
      end
    end
  end

  // Port B output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_b  <= '0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_b <= re_b;
      if (re_b) begin
        rdata_b <= rd_val_b;
      end
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - scoreboard testbench for regfile_2r1w

module tb_regfile_2r1w;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic       re_a;
  logic [2:0] raddr_a;
  logic [7:0] rdata_a;
  logic       rvalid_a;
  logic       re_b;
  logic [2:0] raddr_b;
  logic [7:0] rdata_b;
  logic       rvalid_b;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } exp_t;

  exp_t       qa[$];
  exp_t       qb[$];
  logic [7:0] mdl [8];
  logic [7:0] hold_a;
  logic [7:0] hold_b;
  int         pass_cnt;
  int         total_cnt;

  regfile_2r1w #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re_a     (re_a),
    .raddr_a  (raddr_a),
    .rdata_a  (rdata_a),
    .rvalid_a (rvalid_a),
    .re_b     (re_b),
    .raddr_b  (raddr_b),
    .rdata_b  (rdata_b),
    .rvalid_b (rvalid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_read(input logic w, input logic [2:0] wa,
                                            input logic [7:0] wd, input logic [2:0] ra);
    if (ra == 3'd0) return 8'h00;
    if (w && wa == ra) return wd;
    return mdl[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    hold_a = 8'h00;
    hold_b = 8'h00;
    qa.delete();
    qb.delete();
  endtask

  // Drive one cycle of stimulus, push the expected port outputs, advance
  // past the edge. Comparisons are done by the calling test.
  task automatic drive(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                       input logic ea, input logic [2:0] ra,
                       input logic eb, input logic [2:0] rb);
    exp_t e;
    we = w; waddr = wa; wdata = wd;
    re_a = ea; raddr_a = ra;
    re_b = eb; raddr_b = rb;
    if (ea) hold_a = model_read(w, wa, wd, ra);
    if (eb) hold_b = model_read(w, wa, wd, rb);
    e.v = ea; e.d = hold_a; qa.push_back(e);
    e.v = eb; e.d = hold_b; qb.push_back(e);
    if (w && wa != 3'd0) mdl[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    total_cnt++;
    if ({rvalid_a, rdata_a, rvalid_b, rdata_b} !== 18'h0) begin
      $display("FAIL reset_state: got va=%b a=%h vb=%b b=%h want all 0",
               rvalid_a, rdata_a, rvalid_b, rdata_b);
    end else pass_cnt++;

    drive(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b0, 3'd0);
    void'(qa.pop_front()); void'(qb.pop_front());
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd3);
    e = qa.pop_front();
    total_cnt++;
    if ({rvalid_a, rdata_a} !== e || rdata_a !== 8'hA5) begin
      $display("FAIL reset_preload_a: got %b/%h want %b/%h", rvalid_a, rdata_a, e.v, e.d);
    end else pass_cnt++;
    e = qb.pop_front();
    total_cnt++;
    if ({rvalid_b, rdata_b} !== e) begin
      $display("FAIL reset_preload_b: got %b/%h want %b/%h", rvalid_b, rdata_b, e.v, e.d);
    end else pass_cnt++;

    // Reads in flight, then reset mid-cycle: outputs clear without an edge.
    re_a = 1'b1; raddr_a = 3'd3; re_b = 1'b1; raddr_b = 3'd3; we = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({rvalid_a, rdata_a, rvalid_b, rdata_b} !== 18'h0) begin
      $display("FAIL reset_async: got va=%b a=%h vb=%b b=%h want all 0",
               rvalid_a, rdata_a, rvalid_b, rdata_b);
    end else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
      $display("FAIL reset_drop_inflight: got va=%b vb=%b want 0 0", rvalid_a, rvalid_b);
    end else pass_cnt++;
    rst_n = 1'b1;
    model_reset();

    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0, 3'd0);
    e = qa.pop_front(); void'(qb.pop_front());
    total_cnt++;
    if ({rvalid_a, rdata_a} !== e || rdata_a !== 8'h00) begin
      $display("FAIL reset_r3_cleared: got %b/%h want %b/%h", rvalid_a, rdata_a, e.v, e.d);
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    exp_t e;
    drive(1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 1'b0, 3'd0);
    void'(qa.pop_front()); void'(qb.pop_front());
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b0, 3'd0);
    e = qa.pop_front(); void'(qb.pop_front());
    total_cnt++;
    if ({rvalid_a, rdata_a} !== e || rdata_a !== 8'h3C || rvalid_a !== 1'b1) begin
      $display("FAIL basic_read: got %b/%h want 1/3c", rvalid_a, rdata_a);
    end else pass_cnt++;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    e = qa.pop_front(); void'(qb.pop_front());
    total_cnt++;
    if ({rvalid_a, rdata_a} !== e || rvalid_a !== 1'b0) begin
      $display("FAIL basic_single_pulse: got %b/%h want %b/%h", rvalid_a, rdata_a, e.v, e.d);
    end else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    exp_t e;
    drive(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0);
    void'(qa.pop_front()); void'(qb.pop_front());
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd0);
    e = qa.pop_front();
    total_cnt++;
    if ({rvalid_a, rdata_a} !== e || rdata_a !== 8'h00) begin
      $display("FAIL zero_reg_a: got %b/%h want 1/00", rvalid_a, rdata_a);
    end else pass_cnt++;
    e = qb.pop_front();
    total_cnt++;
    if ({rvalid_b, rdata_b} !== e || rdata_b !== 8'h00) begin
      $display("FAIL zero_reg_b: got %b/%h want 1/00", rvalid_b, rdata_b);
    end else pass_cnt++;
    // Write to r0 together with a read of r0: bypass must not apply.
    drive(1'b1, 3'd0, 8'hEE, 1'b1, 3'd0, 1'b0, 3'd0);
    e = qa.pop_front(); void'(qb.pop_front());
    total_cnt++;
    if ({rvalid_a, rdata_a} !== e || rdata_a !== 8'h00) begin
      $display("FAIL zero_reg_no_bypass: got %b/%h want 1/00", rvalid_a, rdata_a);
    end else pass_cnt++;
  endtask

  task automatic test_bypass();
    exp_t e;
    drive(1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 1'b0, 3'd0);
    void'(qa.pop_front()); void'(qb.pop_front());
    drive(1'b1, 3'd2, 8'h77, 1'b0, 3'd0, 1'b1, 3'd2);
    void'(qa.pop_front()); e = qb.pop_front();
    total_cnt++;
    if ({rvalid_b, rdata_b} !== e || rdata_b !== 8'h77) begin
      $display("FAIL bypass_b: got %b/%h want 1/77", rvalid_b, rdata_b);
    end else pass_cnt++;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd2);
    void'(qa.pop_front()); e = qb.pop_front();
    total_cnt++;
    if ({rvalid_b, rdata_b} !== e || rdata_b !== 8'h77) begin
      $display("FAIL bypass_persist: got %b/%h want 1/77", rvalid_b, rdata_b);
    end else pass_cnt++;
    // Both ports bypassing on the same edge.
    drive(1'b1, 3'd4, 8'h9A, 1'b1, 3'd4, 1'b1, 3'd4);
    e = qa.pop_front();
    total_cnt++;
    if ({rvalid_a, rdata_a} !== e || rdata_a !== 8'h9A) begin
      $display("FAIL bypass_both_a: got %b/%h want 1/9a", rvalid_a, rdata_a);
    end else pass_cnt++;
    e = qb.pop_front();
    total_cnt++;
    if ({rvalid_b, rdata_b} !== e || rdata_b !== 8'h9A) begin
      $display("FAIL bypass_both_b: got %b/%h want 1/9a", rvalid_b, rdata_b);
    end else pass_cnt++;
  endtask

  task automatic test_dual_hold();
    exp_t ea, eb;
    drive(1'b1, 3'd1, 8'h01, 1'b0, 3'd0, 1'b0, 3'd0);
    void'(qa.pop_front()); void'(qb.pop_front());
    drive(1'b1, 3'd7, 8'h80, 1'b0, 3'd0, 1'b0, 3'd0);
    void'(qa.pop_front()); void'(qb.pop_front());
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b1, 3'd7);
    ea = qa.pop_front(); eb = qb.pop_front();
    total_cnt++;
    if ({rvalid_a, rdata_a, rvalid_b, rdata_b} !== {ea, eb} ||
        rdata_a !== 8'h01 || rdata_b !== 8'h80) begin
      $display("FAIL dual_read: got %b/%h %b/%h want 1/01 1/80",
               rvalid_a, rdata_a, rvalid_b, rdata_b);
    end else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd1, 8'h5F, 1'b0, 3'd1, 1'b0, 3'd7);
      ea = qa.pop_front(); eb = qb.pop_front();
      total_cnt++;
      if ({rvalid_a, rdata_a, rvalid_b, rdata_b} !== {ea, eb} ||
          rdata_a !== 8'h01 || rdata_b !== 8'h80 || rvalid_a || rvalid_b) begin
        $display("FAIL dual_hold[%0d]: got %b/%h %b/%h want 0/01 0/80",
                 i, rvalid_a, rdata_a, rvalid_b, rdata_b);
      end else pass_cnt++;
    end
  endtask

  task automatic test_streaming();
    exp_t e;
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 3'(i), 8'(i * 16), 1'b0, 3'd0, 1'b0, 3'd0);
      void'(qa.pop_front()); void'(qb.pop_front());
    end
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b0, 3'd0);
      e = qa.pop_front(); void'(qb.pop_front());
      total_cnt++;
      if ({rvalid_a, rdata_a} !== e || rdata_a !== 8'(i * 16) || rvalid_a !== 1'b1) begin
        $display("FAIL stream[%0d]: got %b/%h want 1/%h", i, rvalid_a, rdata_a, 8'(i * 16));
      end else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t ea, eb;
    for (int n = 0; n < 60; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      ea = qa.pop_front(); eb = qb.pop_front();
      total_cnt++;
      if ({rvalid_a, rdata_a, rvalid_b, rdata_b} !== {ea, eb}) begin
        $display("FAIL random[%0d]: got %b/%h %b/%h want %b/%h %b/%h", n,
                 rvalid_a, rdata_a, rvalid_b, rdata_b, ea.v, ea.d, eb.v, eb.d);
      end else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    we = 1'b0; waddr = 3'd0; wdata = 8'h00;
    re_a = 1'b0; raddr_a = 3'd0;
    re_b = 1'b0; raddr_b = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    test_reset();
    test_basic();
    test_zero_reg();
    test_bypass();
    test_dual_hold();
    test_streaming();
    test_back_to_back();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Small register file that reads back stored words. It is the reader-side counterpart to the gated-latch storage cells.
- Provides one synchronous write port and two independent registered read ports, each with its own read-enable and valid flag.
- Intended as the register bank for the single-cycle MIPS datapath built in later parts.
- Register 0 is hardwired to zero, as in MIPS.

Parameters:
- WIDTH, 8, data word width in bits
- DEPTH, 8, number of registers (power of two)
- ADDR_W, 3, address width; must equal log2(DEPTH)

Ports:
- clk  input  1  single system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- we  input  1  write enable, sampled on rising clk edge
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- re_a  input  1  read enable, port A
- raddr_a  input  ADDR_W  read address, port A
- rdata_a  output  WIDTH  registered read data, port A
- rvalid_a  output  1  port A data valid, one-cycle pulse per accepted read
- re_b  input  1  read enable, port B
- raddr_b  input  ADDR_W  read address, port B
- rdata_b  output  WIDTH  registered read data, port B
- rvalid_b  output  1  port B data valid

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst_n is asynchronous, active-low. Asserting it clears immediately, with no clock edge needed: every register entry, rdata_a, rdata_b, rvalid_a, rvalid_b all go to 0.
  - Deassertion is sampled synchronously.
  - Reset asserted mid-operation drops any read in flight: no rvalid pulse follows.
- Write:
  - On a rising edge with we=1 and waddr!=0, entry[waddr] <= wdata.
  - A write to address 0 is ignored. Entry 0 stays 0 at all times.
- Read latency:
  - On a rising edge with re_x=1: rdata_x <= read value of raddr_x, and rvalid_x <= 1.
  - Data and valid appear together, exactly 1 cycle after the request.
- Read hold:
  - On a rising edge with re_x=0: rvalid_x <= 0 and rdata_x holds its previous value.
  - rdata_x never changes without a corresponding rvalid_x pulse, except on reset.
- Read value rules:
  - raddr_x == 0 reads 0.
  - Write-through bypass: if the same edge also has we=1 and waddr==raddr_x!=0, the read returns wdata, not the old entry.
  - Otherwise the read returns entry[raddr_x].
- Port independence:
  - Ports A and B are fully independent. Same address on both ports returns identical data.
  - Both ports may bypass in the same cycle.
- Back-to-back reads: re_x held high issues one read per cycle and rvalid_x stays high continuously.
- Address range: out-of-range addresses cannot occur because DEPTH = 2^ADDR_W. No error path is needed.
- Implementation:
  - Storage is edge-triggered flip-flops, not latches. No combinational path from inputs to outputs.
  - Width rules: all data paths are WIDTH bits, with no truncation or extension.

Test Plan:
- Reset clears: write 8'hA5 to r3, then pulse rst_n low mid-cycle → rdata_a/b=0 and rvalid_a/b=0 immediately; a following read of r3 returns 8'h00.
- Basic write/read: write r5=8'h3C, next cycle re_a=1 raddr_a=5 → one cycle later rdata_a=8'h3C, rvalid_a=1 for exactly one cycle.
- Zero register: we=1 waddr=0 wdata=8'hFF, then read r0 on both ports → rdata_a=rdata_b=8'h00.
- Bypass: r2=8'h11, then a single edge with we=1 waddr=2 wdata=8'h77 and re_b=1 raddr_b=2 → rdata_b=8'h77 next cycle; a subsequent read also returns 8'h77.
- Dual-port and hold: r1=8'h01, r7=8'h80; read A=1 and B=7 together → 8'h01 and 8'h80 with both rvalid high; then re_a=re_b=0 for 3 cycles → both outputs hold and both rvalid stay 0.
- Streaming: load r1..r7=8'h10..8'h70, hold re_a=1 while sweeping raddr_a 1→7 → rdata_a 8'h10..8'h70 on consecutive cycles, each one cycle late, with rvalid_a continuously 1.
